programmable_ram: RTL and testbench
===================================

Name: programmable_ram

Overview:
- Parametrised successor to the CPU's 16x8 program/data RAM.
- Generalised in data width and depth.
- Adds a power-up clear sweep, a synchronised and edge-detected manual write button, and an auto-incrementing programming pointer.
- Sits on the CPU bus, addressed by the MAR; front-panel switches drive it in manual (programming) mode.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width in bits; DEPTH = 2**ADDR_WIDTH (derived, not overridable).
- SYNC_STAGES, 2, flop count of the manual_mode / manual_write synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- read_from_bus  input  1  RUN mode: write bus_in into data[address] at next edge.
- address  input  ADDR_WIDTH  CPU address (from MAR).
- bus_in  input  DATA_WIDTH  bus data to store.
- bus_out  output  DATA_WIDTH  word at current read address (combinational read).
- manual_mode  input  1  asynchronous front-panel switch; 1 = programming mode.
- manual_write  input  1  asynchronous front-panel write button, active-high.
- manual_address  input  ADDR_WIDTH  address switches.
- manual_auto_inc  input  1  1 = manual writes target manual_pointer instead of manual_address.
- program_switches  input  DATA_WIDTH  data switches.
- manual_pointer  output  ADDR_WIDTH  next auto-increment programming address (for display).
- ready  output  1  high once clear sweep completes.
- parity_error  output  1  read-word parity mismatch (see Optional Feature).

Behaviour:
- State machine states: CLEAR, RUN, MANUAL.
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clear counter=0, manual_pointer=0, ready=0.
  - All synchroniser and edge-detect flops = 0.
  - bus_out=0, parity_error=0.
- CLEAR:
  - One word zeroed per edge, ascending from 0.
  - The edge that zeroes word DEPTH-1 moves state to RUN, or to MANUAL if synced manual_mode=1; ready=1 from that edge.
  - ready therefore rises exactly DEPTH edges after rst_n release.
  - bus_out=0 throughout; read_from_bus and manual presses are ignored; presses are not queued.
- Synchronisers:
  - manual_mode and manual_write each pass through SYNC_STAGES flops.
  - write_pulse = synced manual_write AND NOT its previous value, giving exactly one pulse per press however long it is held.
- RUN:
  - read_from_bus=1 writes data[address] <= bus_in.
  - write_pulse is discarded.
  - Read address = address.
- MANUAL:
  - read_from_bus is ignored.
  - On write_pulse, target = manual_auto_inc ? manual_pointer : manual_address; data[target] <= program_switches.
  - On write_pulse, manual_pointer <= target+1, wrapping DEPTH-1 -> 0.
  - program_switches, manual_address and manual_auto_inc are sampled on the write_pulse cycle. Operator holds them stable; no synchronisation.
  - Read address = manual_auto_inc ? manual_pointer : manual_address.
- Mode changes:
  - RUN<->MANUAL follows synced manual_mode, one edge after the synchroniser output changes.
  - A write_pulse in the same cycle as a mode change is handled by the current (pre-transition) state.
  - manual_pointer persists across mode changes; only rst_n clears it.
- Read:
  - bus_out = data[read address], asynchronous.
  - A write is visible on bus_out immediately after the writing edge.
- Reset mid-operation (mid-sweep or mid-programming):
  - Aborts the operation, restarts the sweep from word 0 and clears the pointer.
  - Previous memory contents are lost.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word carries one extra stored bit, set to even parity (XOR of the data) on every bus, manual and clear write.
  - parity_error = ready AND (XOR of stored word at read address != stored parity bit), combinational.
- Undefined:
  - No extra storage.
  - parity_error tied to 0.

Test Plan:
1. Release rst_n with read_from_bus=1, bus_in=0xFF, address=3 -> ready=0 for edges 1..15, ready=1 after edge 16; all 16 words read 0x00; word 3 not written during CLEAR.
2. RUN, address=5, bus_in=0xA7, read_from_bus=1 for one edge -> bus_out=0xA7 at address 5; address 6 reads 0x00; manual press in RUN leaves memory unchanged.
3. MANUAL, auto_inc=1, three presses (one held 50 cycles) with switches 0x11, 0x22, 0x33 -> words 0,1,2 = 0x11,0x22,0x33; manual_pointer=3; exactly three writes.
4. MANUAL, auto_inc=0, manual_address=15, press 0x5C -> word 15=0x5C, manual_pointer=0; then auto_inc=1, press 0x01 -> word 0=0x01, manual_pointer=1.
5. MANUAL with read_from_bus=1, address=7, bus_in=0x99 -> word 7 stays 0x00; return to RUN after sync latency -> bus write to word 7 succeeds.
6. Assert rst_n low mid-programming (pointer=9, words nonzero) -> pointer=0, ready=0, all words 0x00 after 16 edges. With RAM_PARITY_EN, force-flip one stored data bit of word 2 -> parity_error=1 while address=2, 0 elsewhere.

Source files
------------

// File: rtl/programmable_ram.sv
// programmable_ram -- parametrised program/data RAM for the CPU bus.
//
// Words are cleared one per clock after reset (ready rises when the sweep
// ends). In RUN mode the CPU writes bus_in at the MAR address; in MANUAL
// mode the front-panel write button stores program_switches either at
// manual_address or at the auto-incrementing manual_pointer.
//
// Optional build macro: RAM_PARITY_EN adds one stored even-parity bit per
// word and drives parity_error; without it parity_error is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   read_from_bus     RUN-mode write enable
//   address, bus_in   CPU write/read address and write data
//   bus_out           combinational read of the current read address
//   manual_mode       async switch, 1 = programming mode
//   manual_write      async write button, active-high
//   manual_address    address switches
//   manual_auto_inc   1 = manual writes/reads use manual_pointer
//   program_switches  data switches
//   manual_pointer    next auto-increment programming address
//   ready             high once the clear sweep completes
//   parity_error      stored-word parity mismatch at the read address
module programmable_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_from_bus,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  input  logic                  manual_mode,
  input  logic                  manual_write,
  input  logic [ADDR_WIDTH-1:0] manual_address,
  input  logic                  manual_auto_inc,
  input  logic [DATA_WIDTH-1:0] program_switches,
  output logic [ADDR_WIDTH-1:0] manual_pointer,
  output logic                  ready,
  output logic                  parity_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_MANUAL
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clear_cnt;

  logic [SYNC_STAGES-1:0]  mode_sync;
  logic [SYNC_STAGES-1:0]  write_sync;
  logic                    write_prev;
  logic                    mode_s;
  logic                    write_s;
  logic                    write_pulse;

  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [ADDR_WIDTH-1:0]   manual_target;
  logic [DATA_WIDTH-1:0]   rdata;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------
  // Front-panel synchronisers and press edge detector
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (a shift chain would
  // collapse into one stage with blocking assignments).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync  <= '0;
      write_sync <= '0;
      write_prev <= 1'b0;
    end else begin
      mode_sync  <= {mode_sync[SYNC_STAGES-2:0], manual_mode};
      write_sync <= {write_sync[SYNC_STAGES-2:0], manual_write};
      write_prev <= write_s;
    end
  end

  assign mode_s      = mode_sync[SYNC_STAGES-1];
  assign write_s     = write_sync[SYNC_STAGES-1];
  // One pulse per press regardless of how long the button is held.
  assign write_pulse = write_s & ~write_prev;

  // ---------------------------------------------------------------------
  // Mode state machine and clear-sweep counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clear_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_CLEAR: begin
        if (clear_cnt == ADDR_WIDTH'(DEPTH - 1))
          state_next = mode_s ? ST_MANUAL : ST_RUN;
      end
      ST_RUN:    if (mode_s)  state_next = ST_MANUAL;
      ST_MANUAL: if (!mode_s) state_next = ST_RUN;
      default:   state_next = ST_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write/read port selection
  // ---------------------------------------------------------------------
  assign manual_target = manual_auto_inc ? manual_pointer : manual_address;

  always_comb begin
    we    = 1'b0;
    waddr = clear_cnt;
    wdata = '0;
    raddr = clear_cnt;
    unique case (state)
      ST_CLEAR: begin
        // Sweep has priority over bus and button; nothing is queued.
        we = 1'b1;
      end
      ST_RUN: begin
        raddr = address;
        if (read_from_bus) begin
          we    = 1'b1;
          waddr = address;
          wdata = bus_in;
        end
      end
      ST_MANUAL: begin
        raddr = manual_target;
        if (write_pulse) begin
          we    = 1'b1;
          waddr = manual_target;
          wdata = program_switches;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Programming pointer: only reset clears it, so it survives mode changes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      manual_pointer <= '0;
    end else if (state == ST_MANUAL && write_pulse) begin
      manual_pointer <= manual_target + ADDR_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  // NOTE: the array has no reset branch; the post-reset sweep zeroes it,
  // which keeps it mappable onto plain RAM rather than DEPTH reset flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata   = mem[raddr];
  assign ready   = (state != ST_CLEAR);
  // Contents are undefined until the sweep finishes, so hide them.
  assign bus_out = ready ? rdata : '0;

`ifdef RAM_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_par[waddr] <= ^wdata;
  end

  assign parity_error = ready & ((^rdata) != mem_par[raddr]);
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_programmable_ram.sv
// Self-checking bench for programmable_ram (default parameters).
// A behavioural model (word array, pointer, mode flag) tracks what the
// memory must hold; directed tables and randomized operations are compared
// against it and against hand-derived expected values.
module tb_programmable_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read_from_bus;
  logic [AW-1:0] address;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          manual_mode;
  logic          manual_write;
  logic [AW-1:0] manual_address;
  logic          manual_auto_inc;
  logic [DW-1:0] program_switches;
  logic [AW-1:0] manual_pointer;
  logic          ready;
  logic          parity_error;

  programmable_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_from_bus    (read_from_bus),
    .address          (address),
    .bus_in           (bus_in),
    .bus_out          (bus_out),
    .manual_mode      (manual_mode),
    .manual_write     (manual_write),
    .manual_address   (manual_address),
    .manual_auto_inc  (manual_auto_inc),
    .program_switches (program_switches),
    .manual_pointer   (manual_pointer),
    .ready            (ready),
    .parity_error     (parity_error)
  );

  always #50 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model
  logic [DW-1:0] model_mem [DEPTH];
  int            model_ptr;
  bit            model_manual;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] sw;
    logic          auto_inc;
    logic [AW-1:0] maddr;
    int            hold;
    int            exp_ptr;
    int            exp_addr;
    logic [DW-1:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_ptr = 0;
  endtask

  // Read one word through whichever read path the current mode uses.
  task automatic read_word(input int a, output logic [DW-1:0] d);
    if (model_manual) begin
      manual_auto_inc = 1'b0;
      manual_address  = AW'(a);
    end else begin
      address = AW'(a);
    end
    #1;
    d = bus_out;
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] d;
    logic          perr_any;
    perr_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      read_word(i, d);
      check($sformatf("%s_word%0d", tag, i), 32'(d), 32'(model_mem[i]));
      perr_any = perr_any | parity_error;
    end
    check($sformatf("%s_parity", tag), 32'(perr_any), 32'd0);
  endtask

  task automatic set_mode(input bit m);
    manual_mode = m;
    tick(SYNC + 2);
    model_manual = m;
  endtask

  // One button press; switches held stable until the press has been seen.
  task automatic press(input logic [DW-1:0] sw, input logic auto_inc,
                       input logic [AW-1:0] maddr, input int hold);
    int tgt;
    program_switches = sw;
    manual_auto_inc  = auto_inc;
    manual_address   = maddr;
    manual_write     = 1'b1;
    tick(hold);
    manual_write     = 1'b0;
    tick(SYNC + 3);
    if (model_manual) begin
      tgt = auto_inc ? model_ptr : int'(maddr);
      model_mem[tgt] = sw;
      model_ptr = (tgt + 1) % DEPTH;
    end
  endtask

  // Release reset just after an edge and confirm ready rises on edge DEPTH.
  task automatic release_and_sweep(input string tag);
    rst_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      tick(1);
      check($sformatf("%s_ready_e%0d", tag, e), 32'(ready), (e == DEPTH) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    int            a;
    int            op;

    vecs[0] = '{8'h11, 1'b1, 4'd0,  1,  1, 0,  8'h11};
    vecs[1] = '{8'h22, 1'b1, 4'd9,  50, 2, 1,  8'h22};
    vecs[2] = '{8'h33, 1'b1, 4'd4,  3,  3, 2,  8'h33};
    vecs[3] = '{8'h5C, 1'b0, 4'd15, 2,  0, 15, 8'h5C};
    vecs[4] = '{8'h01, 1'b1, 4'd7,  1,  1, 0,  8'h01};

    // ---- Test 1: reset state and clear sweep --------------------------
    rst_n            = 1'b0;
    read_from_bus    = 1'b1;
    bus_in           = 8'hFF;
    address          = 4'd3;
    manual_mode      = 1'b0;
    manual_write     = 1'b0;
    manual_address   = '0;
    manual_auto_inc  = 1'b0;
    program_switches = '0;
    model_manual     = 1'b0;
    model_clear();
    tick(2);
    check("rst_ready",   32'(ready),          32'd0);
    check("rst_bus_out", 32'(bus_out),        32'd0);
    check("rst_ptr",     32'(manual_pointer), 32'd0);
    check("rst_parity",  32'(parity_error),   32'd0);

    release_and_sweep("t1");
    check("t1_word3_not_written", 32'(bus_out), 32'd0);
    read_from_bus = 1'b0;
    check_all("t1");

    // ---- Test 2: RUN bus write, press ignored in RUN ------------------
    address = 4'd5; bus_in = 8'hA7; read_from_bus = 1'b1;
    tick(1);
    read_from_bus = 1'b0;
    model_mem[5] = 8'hA7;
    check("t2_write_visible", 32'(bus_out), 32'hA7);
    address = 4'd6;
    #1;
    check("t2_neighbour", 32'(bus_out), 32'h00);
    press(8'h3C, 1'b0, 4'd5, 2);
    check("t2_press_ptr", 32'(manual_pointer), 32'd0);
    check_all("t2");

    // ---- Tests 3/4: manual programming vectors ------------------------
    set_mode(1'b1);
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].sw, vecs[i].auto_inc, vecs[i].maddr, vecs[i].hold);
      check($sformatf("vec%0d_ptr", i), 32'(manual_pointer), 32'(vecs[i].exp_ptr));
      read_word(vecs[i].exp_addr, d);
      check($sformatf("vec%0d_word", i), 32'(d), 32'(vecs[i].exp_word));
    end
    // Auto-inc read path shows the word at the pointer (word 1 = 0x22).
    manual_auto_inc = 1'b1;
    #1;
    check("t4_autoinc_read", 32'(bus_out), 32'h22);
    check_all("t4");

    // ---- Test 5: bus ignored in MANUAL, accepted again in RUN ---------
    address = 4'd7; bus_in = 8'h99; read_from_bus = 1'b1;
    tick(3);
    read_from_bus = 1'b0;
    read_word(7, d);
    check("t5_manual_ignores_bus", 32'(d), 32'h00);
    set_mode(1'b0);
    check("t5_ptr_persists", 32'(manual_pointer), 32'd1);
    address = 4'd7; bus_in = 8'h99; read_from_bus = 1'b1;
    tick(1);
    read_from_bus = 1'b0;
    model_mem[7] = 8'h99;
    check("t5_run_write", 32'(bus_out), 32'h99);

    // ---- Randomized operations against the model ----------------------
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        set_mode(!model_manual);
      end else if (op < 5) begin
        a = $urandom_range(0, DEPTH - 1);
        d = DW'($urandom);
        address = AW'(a); bus_in = d; read_from_bus = 1'b1;
        tick(1);
        read_from_bus = 1'b0;
        if (!model_manual) model_mem[a] = d;
      end else begin
        press(DW'($urandom), 1'($urandom), AW'($urandom), $urandom_range(1, 6));
      end
      check("rand_ptr", 32'(manual_pointer), 32'(model_ptr));
      a = $urandom_range(0, DEPTH - 1);
      read_word(a, d);
      check($sformatf("rand_word%0d", a), 32'(d), 32'(model_mem[a]));
    end
    check_all("rand");

    // ---- Test 6: reset mid-programming, then mid-sweep ----------------
    if (!model_manual) set_mode(1'b1);
    press(8'h77, 1'b0, 4'd8, 1);
    check("t6_ptr_before", 32'(manual_pointer), 32'd9);
    #10;
    rst_n = 1'b0;
    #1;
    check("t6_async_ptr",   32'(manual_pointer), 32'd0);
    check("t6_async_ready", 32'(ready),          32'd0);
    check("t6_async_bus",   32'(bus_out),        32'd0);
    tick(2);
    model_clear();
    rst_n = 1'b1;
    tick(7);
    check("t6_mid_sweep_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    tick(1);
    release_and_sweep("t6");
    check("t6_ptr_after", 32'(manual_pointer), 32'd0);
    check_all("t6");
    // Sweep ended in MANUAL (switch still on): presses take effect.
    press(8'hC3, 1'b1, 4'd0, 1);
    check("t6_manual_after_sweep", 32'(manual_pointer), 32'd1);
    check_all("t6b");

`ifdef RAM_PARITY_EN
    dut.mem[2] = dut.mem[2] ^ 8'h01;
    read_word(2, d);
    check("par_flip_addr2", 32'(parity_error), 32'd1);
    read_word(3, d);
    check("par_clean_addr3", 32'(parity_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
